ptvm_ticket_dispenser: RTL and testbench

- Downstream stage of the paper-ticket vending FSM (iiitb_ptvm), instantiated beside it in user_proj_example.
- Converts each vend assertion from the FSM into one timed motor drive pulse, then confirms the ticket drop via an optical sensor on a GPIO pad.
- Queues back-to-back vends, counts issued tickets, and latches a fault on jam or timeout.

---
 rtl/ptvm_pkg.sv | 24 ++
 rtl/ptvm_sync_edge.sv | 31 +++
 rtl/ptvm_ticket_dispenser.sv | 173 +++++++++++++++++
 tb/tb_ptvm_ticket_dispenser.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptvm_pkg.sv
// ptvm_pkg: shared encodings for the paper-ticket vending datapath.
//   - state_e : ticket dispenser FSM state encoding
//   - coin_e  : coin codes shared with the upstream vend FSM
//   - max2    : helper for sizing timers from two cycle counts
package ptvm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRIVE      = 2'd1,
    WAIT_SENSE = 2'd2,
    FAULT      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ptvm_sync_edge.sv
// ptvm_sync_edge: 2-flop synchroniser followed by a registered rising-edge
// detector for asynchronous pad inputs.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   din  - asynchronous level input
//   rise - one-cycle pulse, high 3 clocks after din rises
module ptvm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/ptvm_ticket_dispenser.sv
// ptvm_ticket_dispenser: turns each vend request from the vending FSM into a
// timed motor pulse, confirms the ticket drop through an optical sensor,
// queues back-to-back requests, counts issued tickets and latches a fault on
// a missing ticket.
// Ports:
//   clk           - system clock
//   rst           - synchronous active-high reset
//   vend_i        - vend level, rising edge = one request (synchronous)
//   sense_i       - ticket-drop sensor, asynchronous, rising edge = one ticket
//   clear_fault_i - one-cycle fault clear (pad-synchronised if CLEAR_FROM_PAD)
//   motor_o       - dispenser motor drive
//   busy_o        - state is not IDLE
//   fault_o       - state is FAULT
//   overflow_o    - sticky, a request was lost on a full queue
//   pending_o     - queued requests not yet dispensed
//   issued_o      - confirmed tickets, wraps
module ptvm_ticket_dispenser
  import ptvm_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned CNT_W          = 16,
  parameter bit          CLEAR_FROM_PAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend_i,
  input  logic             sense_i,
  input  logic             clear_fault_i,
  output logic             motor_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic             overflow_o,
  output logic [2:0]       pending_o,
  output logic [CNT_W-1:0] issued_o
);

  localparam int unsigned TMR_W = $clog2(max2(PULSE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       DEPTH4       = 4'(QUEUE_DEPTH);

  state_e           state, state_next;
  logic             prev_vend;
  logic             request, dequeue, requeue, confirm;
  logic             sense_edge, clear_pulse;
  logic [TMR_W-1:0] timer;
  logic [2:0]       pending;
  logic [3:0]       pend_sum;
  logic             lost;
  logic             got_sense;
  logic             overflow;
  logic [CNT_W-1:0] issued;
  logic             motor;

  // ---- input conditioning ----
  ptvm_sync_edge u_sense_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sense_i),
    .rise (sense_edge)
  );

  generate
    if (CLEAR_FROM_PAD) begin : g_clear_pad
      ptvm_sync_edge u_clear_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (clear_fault_i),
        .rise (clear_pulse)
      );
    end else begin : g_clear_direct
      assign clear_pulse = clear_fault_i;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev_vend <= 1'b0;
    else     prev_vend <= vend_i;
  end

  assign request = vend_i & ~prev_vend;
  assign dequeue = (state == IDLE) && (pending != 3'd0);
  assign confirm = (state == WAIT_SENSE) && (got_sense || sense_edge);
  // the failed request goes back in the queue on the way into FAULT
  assign requeue = (state == WAIT_SENSE) && (state_next == FAULT);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (pending != 3'd0) state_next = DRIVE;
      DRIVE:      if (timer == '0) state_next = WAIT_SENSE;
      // a sense edge on the timeout cycle still counts as a ticket
      WAIT_SENSE: if (got_sense || sense_edge) state_next = IDLE;
                  else if (timer == '0)        state_next = FAULT;
      FAULT:      if (clear_pulse) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy_o  = (state != IDLE);
    fault_o = (state == FAULT);
  end

  // registered so the motor line never glitches on state decode
  always_ff @(posedge clk) begin
    if (rst) motor <= 1'b0;
    else     motor <= (state_next == DRIVE);
  end

  // ---- shared drive / timeout timer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else begin
      unique case (state)
        IDLE:       if (dequeue) timer <= PULSE_LOAD;
        DRIVE:      timer <= (timer == '0) ? TIMEOUT_LOAD : timer - TMR_W'(1);
        WAIT_SENSE: if (timer != '0) timer <= timer - TMR_W'(1);
        default:    timer <= timer;
      endcase
    end
  end

  // a ticket can drop while the motor is still running; remember it
  always_ff @(posedge clk) begin
    if (rst)                                  got_sense <= 1'b0;
    else if (state == DRIVE && sense_edge)    got_sense <= 1'b1;
    else if (confirm)                         got_sense <= 1'b0;
  end

  // ---- request queue (a counter, requests carry no payload) ----
  // request and requeue can coincide in the cycle FAULT is entered;
  // dequeue only happens in IDLE so never overlaps requeue.
  always_comb begin
    pend_sum = {1'b0, pending} + 4'(request) + 4'(requeue) - 4'(dequeue);
    lost     = (pend_sum > DEPTH4);
  end

  always_ff @(posedge clk) begin
    if (rst)       pending <= 3'd0;
    else if (lost) pending <= 3'(QUEUE_DEPTH);
    else           pending <= pend_sum[2:0];
  end

  // setting wins over a clear arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst)              overflow <= 1'b0;
    else if (lost)        overflow <= 1'b1;
    else if (clear_pulse) overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)          issued <= '0;
    else if (confirm) issued <= issued + CNT_W'(1);
  end

  assign motor_o    = motor;
  assign overflow_o = overflow;
  assign pending_o  = pending;
  assign issued_o   = issued;

endmodule

// File: tb/tb_ptvm_ticket_dispenser.sv
// Self-checking bench for ptvm_ticket_dispenser. Each expected motor pulse
// width is queued when a vend is issued and compared by a monitor when the
// pulse ends; scenario tasks check the remaining outputs inline.
module tb_ptvm_ticket_dispenser;

  localparam int P  = 4;
  localparam int T  = 10;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vend_i = 1'b0;
  logic          sense_man = 1'b0;
  logic          sense_auto = 1'b0;
  logic          sense_i;
  logic          clear_fault_i = 1'b0;
  logic          motor_o, busy_o, fault_o, overflow_o;
  logic [2:0]    pending_o;
  logic [CW-1:0] issued_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit auto_sense = 1'b0;

  assign sense_i = sense_man | sense_auto;

  always #5 clk = ~clk;

  ptvm_ticket_dispenser #(
    .PULSE_CYCLES   (P),
    .TIMEOUT_CYCLES (T),
    .QUEUE_DEPTH    (D),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vend_i        (vend_i),
    .sense_i       (sense_i),
    .clear_fault_i (clear_fault_i),
    .motor_o       (motor_o),
    .busy_o        (busy_o),
    .fault_o       (fault_o),
    .overflow_o    (overflow_o),
    .pending_o     (pending_o),
    .issued_o      (issued_o)
  );

  // pulse monitor + optional sensor responder
  int width = 0;
  bit mprev = 1'b0;
  int scnt  = 0;
  int exp_w;
  always @(negedge clk) begin
    if (rst) begin
      width = 0; mprev = 1'b0; scnt = 0; sense_auto = 1'b0;
    end else begin
      if (motor_o) width++;
      else if (mprev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: width %0d, no pulse expected", width);
        end else begin
          exp_w = exp_q.pop_front();
          if (width !== exp_w) begin
            errors++;
            $display("FAIL pulse_width: got %0d expected %0d", width, exp_w);
          end
        end
        width = 0;
        if (auto_sense) scnt = 4;
      end
      if (scnt > 0) begin sense_auto = 1'b1; scnt--; end
      else sense_auto = 1'b0;
      mprev = motor_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_missing: %0d pulses outstanding, expected 0", exp_q.size());
    end
    rst = 1'b1; vend_i = 1'b0; sense_man = 1'b0; clear_fault_i = 1'b0; auto_sense = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic vend_pulse();
    vend_i = 1'b1; @(negedge clk);
    vend_i = 1'b0; @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy_o || pending_o != 3'd0) && n < budget) begin @(negedge clk); n++; end
    if (busy_o || pending_o != 3'd0) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: busy %0b pending %0d after %0d cycles, expected idle",
               tag, busy_o, pending_o, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (motor_o !== 1'b0)     begin errors++; $display("FAIL reset_motor: got %b expected 0", motor_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (fault_o !== 1'b0)     begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
    checks++; if (overflow_o !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++; if (pending_o !== 3'd0)   begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending_o); end
    checks++; if (issued_o !== 4'd0)    begin errors++; $display("FAIL reset_issued: got %0d expected 0", issued_o); end
  endtask

  task automatic test_single_vend();
    do_reset();
    auto_sense = 1'b1;
    exp_q.push_back(P);
    @(negedge clk);
    vend_i = 1'b1;
    @(negedge clk);
    checks++; if (pending_o !== 3'd1) begin errors++; $display("FAIL single_pending: got %0d expected 1", pending_o); end
    checks++; if (motor_o !== 1'b0)   begin errors++; $display("FAIL single_motor_early: got %b expected 0", motor_o); end
    @(negedge clk);
    for (int i = 0; i < P; i++) begin
      vend_i = 1'b0;
      checks++; if (motor_o !== 1'b1) begin errors++; $display("FAIL single_motor_hi: cycle %0d got %b expected 1", i, motor_o); end
      @(negedge clk);
    end
    checks++; if (motor_o !== 1'b0) begin errors++; $display("FAIL single_motor_lo: got %b expected 0", motor_o); end
    checks++; if (busy_o !== 1'b1)  begin errors++; $display("FAIL single_busy_wait: got %b expected 1", busy_o); end
    wait_idle(40, "single");
    checks++; if (issued_o !== 4'd1)  begin errors++; $display("FAIL single_issued: got %0d expected 1", issued_o); end
    checks++; if (pending_o !== 3'd0) begin errors++; $display("FAIL single_pending_end: got %0d expected 0", pending_o); end
    checks++; if (fault_o !== 1'b0)   begin errors++; $display("FAIL single_fault: got %b expected 0", fault_o); end
  endtask

  task automatic test_early_sense();
    int n = 0;
    do_reset();
    exp_q.push_back(P);
    vend_i = 1'b1; @(negedge clk);
    vend_i = 1'b0; @(negedge clk);
    sense_man = 1'b1;
    repeat (2) @(negedge clk);
    sense_man = 1'b0;
    while (motor_o && n < 20) begin @(negedge clk); n++; end
    checks++; if (motor_o !== 1'b0) begin errors++; $display("FAIL early_drive_end: motor %b expected 0", motor_o); end
    checks++; if (issued_o !== 4'd0) begin errors++; $display("FAIL early_issued_pre: got %0d expected 0", issued_o); end
    @(negedge clk);
    checks++; if (issued_o !== 4'd1) begin errors++; $display("FAIL early_issued: got %0d expected 1", issued_o); end
    checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL early_busy: got %b expected 0", busy_o); end
    repeat (15) @(negedge clk);
    checks++; if (fault_o !== 1'b0)  begin errors++; $display("FAIL early_fault: got %b expected 0", fault_o); end
    checks++; if (issued_o !== 4'd1) begin errors++; $display("FAIL early_issued_hold: got %0d expected 1", issued_o); end
  endtask

  task automatic test_queue_overflow();
    int peak = 0;
    do_reset();
    auto_sense = 1'b1;
    repeat (3) exp_q.push_back(P);
    for (int i = 0; i < 4; i++) begin
      vend_i = 1'b1; @(negedge clk);
      if (int'(pending_o) > peak) peak = int'(pending_o);
      vend_i = 1'b0; @(negedge clk);
      if (int'(pending_o) > peak) peak = int'(pending_o);
    end
    checks++; if (peak !== 2)           begin errors++; $display("FAIL queue_peak: got %0d expected 2", peak); end
    checks++; if (overflow_o !== 1'b1)  begin errors++; $display("FAIL queue_overflow: got %b expected 1", overflow_o); end
    wait_idle(100, "queue");
    checks++; if (issued_o !== 4'd3)    begin errors++; $display("FAIL queue_issued: got %0d expected 3", issued_o); end
    checks++; if (overflow_o !== 1'b1)  begin errors++; $display("FAIL queue_overflow_sticky: got %b expected 1", overflow_o); end
    clear_fault_i = 1'b1; @(negedge clk);
    clear_fault_i = 1'b0;
    checks++; if (overflow_o !== 1'b0)  begin errors++; $display("FAIL queue_overflow_clear: got %b expected 0", overflow_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL queue_busy_after_clear: got %b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    auto_sense = 1'b1;
    repeat (2) exp_q.push_back(P);
    vend_pulse();
    vend_pulse();
    while (busy_o && n < 40) begin @(negedge clk); n++; end
    checks++; if (busy_o !== 1'b0 || pending_o !== 3'd1) begin
      errors++; $display("FAIL b2b_gap: busy %b pending %0d expected busy 0 pending 1", busy_o, pending_o);
    end
    @(negedge clk);
    checks++; if (motor_o !== 1'b1 || pending_o !== 3'd0) begin
      errors++; $display("FAIL b2b_restart: motor %b pending %0d expected motor 1 pending 0", motor_o, pending_o);
    end
    wait_idle(40, "b2b");
    checks++; if (issued_o !== 4'd2) begin errors++; $display("FAIL b2b_issued: got %0d expected 2", issued_o); end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    exp_q.push_back(P);
    vend_pulse();
    while (motor_o && n < 20) begin @(negedge clk); n++; end
    repeat (T - 1) @(negedge clk);
    checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL timeout_early: fault %b expected 0", fault_o); end
    @(negedge clk);
    checks++; if (fault_o !== 1'b1)   begin errors++; $display("FAIL timeout_fault: got %b expected 1", fault_o); end
    checks++; if (pending_o !== 3'd1) begin errors++; $display("FAIL timeout_requeue: got %0d expected 1", pending_o); end
    checks++; if (motor_o !== 1'b0)   begin errors++; $display("FAIL timeout_motor: got %b expected 0", motor_o); end
    repeat (3) @(negedge clk);
    checks++; if (fault_o !== 1'b1)   begin errors++; $display("FAIL timeout_hold: got %b expected 1", fault_o); end
    auto_sense = 1'b1;
    exp_q.push_back(P);
    clear_fault_i = 1'b1; @(negedge clk);
    clear_fault_i = 1'b0;
    checks++; if (fault_o !== 1'b0)   begin errors++; $display("FAIL timeout_clear: got %b expected 0", fault_o); end
    wait_idle(40, "timeout");
    checks++; if (issued_o !== 4'd1)  begin errors++; $display("FAIL timeout_issued: got %0d expected 1", issued_o); end
    checks++; if (fault_o !== 1'b0)   begin errors++; $display("FAIL timeout_fault_end: got %b expected 0", fault_o); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    auto_sense = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(P);
      vend_pulse();
      wait_idle(40, "wrap");
      if (i == 14) begin
        checks++; if (issued_o !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", issued_o); end
      end
    end
    checks++; if (issued_o !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", issued_o); end
    exp_q.push_back(P);
    vend_pulse();
    wait_idle(40, "wrap_extra");
    checks++; if (issued_o !== 4'd1) begin errors++; $display("FAIL wrap_one: got %0d expected 1", issued_o); end
    // second vend queued while the first is being driven, then reset hits
    vend_pulse();
    vend_pulse();
    checks++; if (motor_o !== 1'b1 || pending_o !== 3'd1) begin
      errors++; $display("FAIL rst_pre: motor %b pending %0d expected motor 1 pending 1", motor_o, pending_o);
    end
    rst = 1'b1; @(negedge clk);
    checks++; if (motor_o !== 1'b0)   begin errors++; $display("FAIL rst_motor: got %b expected 0", motor_o); end
    checks++; if (pending_o !== 3'd0) begin errors++; $display("FAIL rst_pending: got %0d expected 0", pending_o); end
    checks++; if (issued_o !== 4'd0)  begin errors++; $display("FAIL rst_issued: got %0d expected 0", issued_o); end
    checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy_o !== 1'b0 || motor_o !== 1'b0) begin
      errors++; $display("FAIL rst_stays_idle: busy %b motor %b expected 0 0", busy_o, motor_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_vend();
    test_early_sense();
    test_queue_overflow();
    test_back_to_back();
    test_timeout();
    test_wrap_reset();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
